// File: rtl/gf_inverter_seq.sv
// Multi-cycle GF(2^M) inverter: y = x^(2^M-2) by square-and-multiply, 0 maps to 0.
// Optional GF_INV_EARLY_EXIT_EN: operands 0 and 1 bypass the CALC phase.
module gf_inverter_seq #(
    parameter int         M    = 8,
    parameter logic [M:0] POLY = 9'h11B
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] byte_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] byte_out,
    output logic         busy
);

    localparam logic [1:0]   S_IDLE   = 2'd0;
    localparam logic [1:0]   S_CALC   = 2'd1;
    localparam logic [1:0]   S_DONE   = 2'd2;
    localparam logic [4:0]   CNT_LAST = 5'(M - 2);
    localparam logic [M-1:0] GF_ZERO  = {M{1'b0}};
    localparam logic [M-1:0] GF_ONE   = {{(M-1){1'b0}}, 1'b1};

    // Interleaved shift-and-xor product; the shifted operand is reduced every step.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = GF_ZERO;
        sh  = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            if (sh[M-1]) begin
                sh = (sh << 1) ^ POLY[M-1:0];
            end else begin
                sh = sh << 1;
            end
        end
        return acc;
    endfunction

    logic [1:0]   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [M-1:0] x_q, x_d;
    logic [M-1:0] y_q, y_d;
    logic [M-1:0] byte_out_q, byte_out_d;
    logic         out_valid_q, out_valid_d;
    logic [M-1:0] sq_s;
    logic [M-1:0] step_s;

    assign sq_s   = gf_mul(y_q, y_q);
    assign step_s = gf_mul(sq_s, x_q);

    // Next-state and datapath decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        byte_out_d  = byte_out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = byte_in;
                    y_d     = byte_in;
                    cnt_d   = 5'd0;
                    state_d = S_CALC;
`ifdef GF_INV_EARLY_EXIT_EN
                    if (byte_in <= GF_ONE) begin
                        byte_out_d  = byte_in;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                // Last step is a bare square: exponent 2^M-2 has a zero LSB.
                if (cnt_q == CNT_LAST) begin
                    y_d         = sq_s;
                    byte_out_d  = sq_s;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    y_d   = step_s;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            x_q         <= GF_ZERO;
            y_q         <= GF_ZERO;
            byte_out_q  <= GF_ZERO;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            byte_out_q  <= byte_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign byte_out  = byte_out_q;

endmodule
